// File: rtl/vec_pkg.sv
// Shared types for the RSA vector pipeline lane ALU.
// Lane geometry, packed lane/flag vectors and ALU opcodes.
package vec_pkg;

  localparam int unsigned LANES  = 6;
  localparam int unsigned LANE_W = 8;

  typedef logic [LANES-1:0][LANE_W-1:0] lane_vec_t;
  typedef logic [1:0][LANES-1:0] lane_flags_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_MOV = 3'b010,
    ALU_MUL = 3'b011
  } alu_op_e;

  function automatic logic is_legal_op(
    input logic [2:0] op
  );
    return ~op[2];
  endfunction

endpackage

// File: rtl/vec_alu_issue_ctrl.sv
// Issue controller for the lane ALU: command in, operands out,
// fixed-latency result capture and response handshake.
module vec_alu_issue_ctrl
  import vec_pkg::*;
#(
  parameter int unsigned ALU_LAT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  lane_vec_t   cmd_a,
  input  lane_vec_t   cmd_b,
  output lane_vec_t   alu_src_a,
  output lane_vec_t   alu_src_b,
  output logic [2:0]  alu_ctrl,
  input  lane_vec_t   alu_vector,
  input  lane_flags_t alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output lane_vec_t   rsp_vector,
  output lane_flags_t rsp_flags,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned CW =
    (ALU_LAT < 1) ? 1 : $clog2(ALU_LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  lane_vec_t   src_a_q, src_a_d;
  lane_vec_t   src_b_q, src_b_d;
  logic [2:0]  ctrl_q, ctrl_d;
  lane_vec_t   vec_q, vec_d;
  lane_flags_t flg_q, flg_d;
  logic        err_q, err_d;
  logic        accept;

  assign cmd_ready = (state_q == S_IDLE)
                   | ((state_q == S_RESP) & rsp_ready);
  assign accept    = cmd_valid & cmd_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    src_a_d = src_a_q;
    src_b_d = src_b_q;
    ctrl_d  = ctrl_q;
    vec_d   = vec_q;
    flg_d   = flg_q;
    err_d   = err_q;
    unique case (state_q)
      S_EXEC: begin
        if (cnt_q == '0) begin
          vec_d   = alu_vector;
          flg_d   = alu_flags;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        if (state_q == S_RESP && rsp_ready)
          state_d = S_IDLE;
        // Illegal ops bypass the ALU and leave its ports untouched.
        if (accept) begin
          if (is_legal_op(cmd_op)) begin
            src_a_d = cmd_a;
            src_b_d = cmd_b;
            ctrl_d  = cmd_op;
            cnt_d   = CW'(ALU_LAT);
            state_d = S_EXEC;
          end else begin
            vec_d   = '0;
            flg_d   = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      src_a_q <= '0;
      src_b_q <= '0;
      ctrl_q  <= '0;
      vec_q   <= '0;
      flg_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_a_q <= src_a_d;
      src_b_q <= src_b_d;
      ctrl_q  <= ctrl_d;
      vec_q   <= vec_d;
      flg_q   <= flg_d;
      err_q   <= err_d;
    end
  end

  assign alu_src_a  = src_a_q;
  assign alu_src_b  = src_b_q;
  assign alu_ctrl   = ctrl_q;
  assign rsp_valid  = (state_q == S_RESP);
  assign rsp_vector = vec_q;
  assign rsp_flags  = flg_q;
  assign rsp_err    = err_q;
  assign busy       = (state_q != S_IDLE);

endmodule
